// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU result queues, round-robin grant, registered broadcast.
// Define CDB_LS_PRIORITY_EN to make LS win whenever its queue is non-empty.
module cdb_arbiter #(
  parameter int QUEUE_DEPTH  = 2,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 5,
  parameter int CNT_W        = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rob_is_mispred,
  input  logic                    in_alu_valid,
  input  logic [GPR_SIZE-1:0]     in_alu_value,
  input  logic [ROB_IDX_SIZE-1:0] in_alu_dst_rob_index,
  input  logic                    in_alu_set_nzcv,
  input  logic [3:0]              in_alu_nzcv,
  output logic                    out_alu_ready,
  input  logic                    in_ls_valid,
  input  logic [GPR_SIZE-1:0]     in_ls_value,
  input  logic [ROB_IDX_SIZE-1:0] in_ls_dst_rob_index,
  output logic                    out_ls_ready,
  output logic                    out_cdb_done,
  output logic [ROB_IDX_SIZE-1:0] out_cdb_rob_index,
  output logic [GPR_SIZE-1:0]     out_cdb_value,
  output logic                    out_cdb_set_nzcv,
  output logic [3:0]              out_cdb_nzcv,
  output logic                    out_cdb_fu_id
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic FU_ALU = 1'b0;
  localparam logic FU_LS  = 1'b1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [GPR_SIZE-1:0]     alu_val_mem  [QUEUE_DEPTH];
  logic [ROB_IDX_SIZE-1:0] alu_rob_mem  [QUEUE_DEPTH];
  logic                    alu_setf_mem [QUEUE_DEPTH];
  logic [3:0]              alu_nzcv_mem [QUEUE_DEPTH];
  logic [GPR_SIZE-1:0]     ls_val_mem   [QUEUE_DEPTH];
  logic [ROB_IDX_SIZE-1:0] ls_rob_mem   [QUEUE_DEPTH];

  logic [PTR_W-1:0] alu_head_q, alu_head_d;
  logic [PTR_W-1:0] alu_tail_q, alu_tail_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d;
  logic [PTR_W-1:0] ls_head_q, ls_head_d;
  logic [PTR_W-1:0] ls_tail_q, ls_tail_d;
  logic [CNT_W-1:0] ls_cnt_q, ls_cnt_d;
  logic             last_grant_q, last_grant_d;

  logic                    cdb_done_q, cdb_done_d;
  logic [ROB_IDX_SIZE-1:0] cdb_rob_q, cdb_rob_d;
  logic [GPR_SIZE-1:0]     cdb_val_q, cdb_val_d;
  logic                    cdb_setf_q, cdb_setf_d;
  logic [3:0]              cdb_nzcv_q, cdb_nzcv_d;
  logic                    cdb_fu_q, cdb_fu_d;

  logic alu_ne, ls_ne;
  logic grant_alu, grant_ls;
  logic alu_push, ls_push;
  logic flush;

  assign flush         = in_rob_is_mispred;
  assign out_alu_ready = (alu_cnt_q != FULL);
  assign out_ls_ready  = (ls_cnt_q != FULL);
  assign alu_ne        = (alu_cnt_q != '0);
  assign ls_ne         = (ls_cnt_q != '0);
  assign alu_push      = in_alu_valid & out_alu_ready & ~flush;
  assign ls_push       = in_ls_valid & out_ls_ready & ~flush;

`ifdef CDB_LS_PRIORITY_EN
  assign grant_ls  = ls_ne;
  assign grant_alu = alu_ne & ~ls_ne;
`else
  // On contention the FU that did not win last time takes the bus.
  always_comb begin
    grant_alu = 1'b0;
    grant_ls  = 1'b0;
    if (alu_ne && ls_ne) begin
      grant_alu = (last_grant_q == FU_LS);
      grant_ls  = (last_grant_q == FU_ALU);
    end else begin
      grant_alu = alu_ne;
      grant_ls  = ls_ne;
    end
  end
`endif

  always_comb begin
    alu_head_d = alu_head_q;
    alu_tail_d = alu_tail_q;
    alu_cnt_d  = alu_cnt_q;
    ls_head_d  = ls_head_q;
    ls_tail_d  = ls_tail_q;
    ls_cnt_d   = ls_cnt_q;
    if (flush) begin
      alu_head_d = '0;
      alu_tail_d = '0;
      alu_cnt_d  = '0;
      ls_head_d  = '0;
      ls_tail_d  = '0;
      ls_cnt_d   = '0;
    end else begin
      if (alu_push) alu_tail_d = alu_tail_q + PTR_ONE;
      if (grant_alu) alu_head_d = alu_head_q + PTR_ONE;
      unique case ({alu_push, grant_alu})
        2'b10:   alu_cnt_d = alu_cnt_q + CNT_ONE;
        2'b01:   alu_cnt_d = alu_cnt_q - CNT_ONE;
        default: alu_cnt_d = alu_cnt_q;
      endcase
      if (ls_push) ls_tail_d = ls_tail_q + PTR_ONE;
      if (grant_ls) ls_head_d = ls_head_q + PTR_ONE;
      unique case ({ls_push, grant_ls})
        2'b10:   ls_cnt_d = ls_cnt_q + CNT_ONE;
        2'b01:   ls_cnt_d = ls_cnt_q - CNT_ONE;
        default: ls_cnt_d = ls_cnt_q;
      endcase
    end
  end

  // Data registers hold their last broadcast when there is no grant.
  always_comb begin
    cdb_done_d   = 1'b0;
    cdb_rob_d    = cdb_rob_q;
    cdb_val_d    = cdb_val_q;
    cdb_setf_d   = cdb_setf_q;
    cdb_nzcv_d   = cdb_nzcv_q;
    cdb_fu_d     = cdb_fu_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      last_grant_d = FU_LS;
    end else if (grant_alu) begin
      cdb_done_d   = 1'b1;
      cdb_rob_d    = alu_rob_mem[alu_head_q];
      cdb_val_d    = alu_val_mem[alu_head_q];
      cdb_setf_d   = alu_setf_mem[alu_head_q];
      cdb_nzcv_d   = alu_nzcv_mem[alu_head_q];
      cdb_fu_d     = FU_ALU;
      last_grant_d = FU_ALU;
    end else if (grant_ls) begin
      cdb_done_d   = 1'b1;
      cdb_rob_d    = ls_rob_mem[ls_head_q];
      cdb_val_d    = ls_val_mem[ls_head_q];
      cdb_setf_d   = 1'b0;
      cdb_nzcv_d   = 4'b0000;
      cdb_fu_d     = FU_LS;
      last_grant_d = FU_LS;
    end
  end

  always_ff @(posedge in_clk) begin
    if (alu_push) begin
      alu_val_mem[alu_tail_q]  <= in_alu_value;
      alu_rob_mem[alu_tail_q]  <= in_alu_dst_rob_index;
      alu_setf_mem[alu_tail_q] <= in_alu_set_nzcv;
      alu_nzcv_mem[alu_tail_q] <= in_alu_nzcv;
    end
    if (ls_push) begin
      ls_val_mem[ls_tail_q] <= in_ls_value;
      ls_rob_mem[ls_tail_q] <= in_ls_dst_rob_index;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      alu_head_q   <= '0;
      alu_tail_q   <= '0;
      alu_cnt_q    <= '0;
      ls_head_q    <= '0;
      ls_tail_q    <= '0;
      ls_cnt_q     <= '0;
      last_grant_q <= FU_LS;
      cdb_done_q   <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_val_q    <= '0;
      cdb_setf_q   <= 1'b0;
      cdb_nzcv_q   <= 4'b0000;
      cdb_fu_q     <= FU_ALU;
    end else begin
      alu_head_q   <= alu_head_d;
      alu_tail_q   <= alu_tail_d;
      alu_cnt_q    <= alu_cnt_d;
      ls_head_q    <= ls_head_d;
      ls_tail_q    <= ls_tail_d;
      ls_cnt_q     <= ls_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_done_q   <= cdb_done_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_val_q    <= cdb_val_d;
      cdb_setf_q   <= cdb_setf_d;
      cdb_nzcv_q   <= cdb_nzcv_d;
      cdb_fu_q     <= cdb_fu_d;
    end
  end

  assign out_cdb_done      = cdb_done_q;
  assign out_cdb_rob_index = cdb_rob_q;
  assign out_cdb_value     = cdb_val_q;
  assign out_cdb_set_nzcv  = cdb_setf_q;
  assign out_cdb_nzcv      = cdb_nzcv_q;
  assign out_cdb_fu_id     = cdb_fu_q;

endmodule
